comb_sweep_ctrl: RTL and testbench
==================================

// Module: comb_sweep_ctrl
// PURPOSE
//  Exhaustive-sweep sequencer for the flat combinational benchmark netlists (11-in / 30-out class).
//  Drives every input vector 0..2^NUM_IN-1 into the DUT, waits a settle window, then folds the DUT outputs into a MISR signature.
//  Used in the silicon/FPGA validation wrapper around the generated netlists, with a start/done handshake toward the host.
// PARAMETERS
//  NUM_IN        11             DUT input width; sweep length 2^NUM_IN
//  NUM_OUT       30             DUT output width; must be <= SIG_W
//  SIG_W         32             MISR width
//  POLY          32'h04C1_1DB7  MISR feedback polynomial, SIG_W bits
//  SEED          32'hFFFF_FFFF  MISR value loaded on start
//  SETTLE_CYCLES 1              cycles each vector is held before capture; >= 1
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        begin sweep; sampled only in IDLE
//  abort      in   1        cancel sweep in progress
//  busy       out  1        high in SETTLE and CAPTURE
//  done       out  1        one-cycle pulse when a full sweep has completed
//  aborted    out  1        sticky; set by abort, cleared by the next accepted start
//  dut_in     out  NUM_IN   registered stimulus to the DUT
//  dut_out    in   NUM_OUT  DUT response
//  signature  out  SIG_W    MISR value; stable from done until the next start
//  vec_idx    out  NUM_IN   index of the vector being applied
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, aborted=0, dut_in=0, vec_idx=0, signature=SEED.
//  FSM states: IDLE, SETTLE, CAPTURE, DONE.
//   IDLE:    start=1 -> signature<=SEED, dut_in<=0, vec_idx<=0, aborted<=0, settle_cnt<=SETTLE_CYCLES-1; next SETTLE.
//   SETTLE:  held for exactly SETTLE_CYCLES cycles, counting settle_cnt down to 0; then CAPTURE.
//   CAPTURE: one cycle. signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(dut_out).
//            If vec_idx==2^NUM_IN-1: next DONE. Otherwise vec_idx++, dut_in<=vec_idx+1, reload settle_cnt, next SETTLE.
//   DONE:    done=1 for this single cycle; dut_in<=0; next IDLE.
//  Latency: (SETTLE_CYCLES+1)*2^NUM_IN cycles from accepted start to entry into DONE.
//  dut_in == vec_idx at all times during SETTLE and CAPTURE; both are registered, with no combinational path from dut_out.
//  start while not in IDLE (including DONE) is ignored; no queueing.
//  abort in SETTLE or CAPTURE: next state IDLE, aborted<=1, dut_in<=0, signature frozen, done never pulses. abort in IDLE or DONE is ignored.
//  start and abort both high in IDLE: start wins; abort is ignored.
//  The vec_idx counter is NUM_IN bits. Termination compares against all-ones, so the counter never wraps.
//  rst_n asserted mid-sweep: immediate return to reset values; no partial signature is retained.
// CONFIGURATION
//  SIG_EXPECT_EN defined: adds input sig_expected[SIG_W] and output pass[1].
//   pass is registered in CAPTURE of the last vector: pass = (next signature == sig_expected). It is valid while done=1, holds until the next accepted start, and is cleared by reset and by start.
//  SIG_EXPECT_EN undefined: the sig_expected and pass ports are absent and no compare logic is built.
// STRUCTURE
//  Package comb_sweep_pkg: state_e enum (IDLE, SETTLE, CAPTURE, DONE); DEF_POLY and DEF_SEED constants; function misr_next(sig, din, poly).
//  Sub-module sweep_misr (SIG_W, POLY, SEED): has load and shift-enable inputs and an output-fold input; holds the signature register.
//  The top level holds the FSM, the settle counter, the vector counter and the handshake.
// TESTING
//  1 Reset: drive rst_n=0 mid-sweep (vec_idx=5). Same cycle, without waiting for a clock: busy=0, dut_in=0, signature=32'hFFFF_FFFF.
//  2 Latency: NUM_IN=11, SETTLE_CYCLES=1, pulse start at edge 0. done is high only in the cycle after edge 4096 (first entry into DONE); busy is low in that cycle.
//  3 Known signature: NUM_IN=2, SEED=1, dut_out tied to 0. After done, signature=32'h0000_0010; vec_idx sequence 0,1,2,3.
//  4 Reference DUT: NUM_IN=11, a model of f1=~x7|x8 driving all 30 outputs. The bench's MISR model matches signature. With SIG_EXPECT_EN: pass=1; with sig_expected flipped in bit 0: pass=0.
//  5 Abort: abort at vec_idx=3. Next cycle: IDLE, busy=0, aborted=1, dut_in=0, no done pulse. The next start clears aborted.
//  6 Contention: start held continuously through a sweep produces exactly one sweep per IDLE visit. start+abort in IDLE: sweep begins and aborted=0.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared types, default constants and the MISR step function for the
// exhaustive-sweep sequencer.
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;

    // One MISR step: shift left, apply the feedback polynomial when the
    // outgoing bit is set, then fold in the response word.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] din,
                                              input logic [31:0] poly);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ din;
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Signature register for the sweep sequencer. Loads SEED on request and
// advances one MISR step per shift-enable, folding in the given word.
module sweep_misr
    import comb_sweep_pkg::*;
#(
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] signature
);

    logic [SIG_W-1:0] sig_next;

    // The package helper is fixed at 32 bits; other widths use the same
    // recurrence written out generically.
    if (SIG_W == 32) begin : g_pkg_step
        assign sig_next = misr_next(signature, din, POLY);
    end else begin : g_generic_step
        assign sig_next = {signature[SIG_W-2:0], 1'b0}
                        ^ (signature[SIG_W-1] ? POLY : '0)
                        ^ din;
    end

    // Signature register: reset and load both return to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= SEED;
        end else if (load) begin
            signature <= SEED;
        end else if (shift_en) begin
            signature <= sig_next;
        end
    end

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive-sweep sequencer: applies every input vector to a flat
// combinational netlist, holds each for SETTLE_CYCLES, then folds the
// response into a MISR signature. Start/done/abort handshake to the host.
// Optional macro SIG_EXPECT_EN adds sig_expected input and pass output.
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int               NUM_IN        = 11,
    parameter int               NUM_OUT       = 30,
    parameter int               SIG_W         = 32,
    parameter logic [SIG_W-1:0] POLY          = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED          = SIG_W'(DEF_SEED),
    parameter int               SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic [SIG_W-1:0]   signature,
    output logic [NUM_IN-1:0]  vec_idx
`ifdef SIG_EXPECT_EN
    ,
    input  logic [SIG_W-1:0]   sig_expected,
    output logic               pass
`endif
);

    // A single-cycle settle still needs a one-bit counter that stays at 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] settle_cnt;
    logic             accept_start;
    logic             do_abort;
    logic             capture;
    logic             last_vec;
    logic [SIG_W-1:0] fold;

    assign last_vec = (vec_idx == '1);
    assign busy     = (state == SETTLE) || (state == CAPTURE);
    assign done     = (state == DONE);

    // Zero-extend the DUT response to the signature width.
    always_comb begin
        fold                = '0;
        fold[NUM_OUT-1:0]   = dut_out;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the one-cycle control strobes for the datapath.
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        do_abort     = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else if (settle_cnt == '0) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else begin
                    capture    = 1'b1;
                    next_state = last_vec ? DONE : SETTLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Vector counter, registered stimulus, settle counter and abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in     <= '0;
            vec_idx    <= '0;
            aborted    <= 1'b0;
            settle_cnt <= '0;
        end else if (accept_start) begin
            dut_in     <= '0;
            vec_idx    <= '0;
            aborted    <= 1'b0;
            settle_cnt <= SETTLE_RELOAD;
        end else if (do_abort) begin
            aborted    <= 1'b1;
            dut_in     <= '0;
        end else if (capture && !last_vec) begin
            vec_idx    <= vec_idx + NUM_IN'(1);
            dut_in     <= vec_idx + NUM_IN'(1);
            settle_cnt <= SETTLE_RELOAD;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end else if (state == DONE) begin
            dut_in     <= '0;
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_start),
        .shift_en  (capture),
        .din       (fold),
        .signature (signature)
    );

`ifdef SIG_EXPECT_EN
    logic [SIG_W-1:0] sig_next;

    assign sig_next = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ fold;

    // Verdict is taken on the final capture so it is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (accept_start) begin
            pass <= 1'b0;
        end else if (capture && last_vec) begin
            pass <= (sig_next == sig_expected);
        end
    end
`endif

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Self-checking bench for comb_sweep_ctrl: an 11-input instance driving a
// model of f1=~x7|x8 on all outputs, and a 2-input instance with outputs
// tied low. Expected signatures and vector indices go through queues.
module tb_comb_sweep_ctrl;

    localparam logic [31:0] POLY_C = 32'h04C1_1DB7;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [10:0] dut_in;
    logic [29:0] dut_out;
    logic [31:0] signature;
    logic [10:0] vec_idx;

    logic        start_s = 1'b0;
    logic        abort_s = 1'b0;
    logic        busy_s;
    logic        done_s;
    logic        aborted_s;
    logic [1:0]  dut_in_s;
    logic [29:0] dut_out_s = '0;
    logic [31:0] sig_s;
    logic [1:0]  vec_idx_s;

`ifdef SIG_EXPECT_EN
    logic [31:0] sig_expected   = '0;
    logic        pass;
    logic [31:0] sig_expected_s = 32'h0000_0010;
    logic        pass_s;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] sigQ[$];
    logic [1:0]  idxQ[$];

    always #5 clk = ~clk;

    assign dut_out = {30{~dut_in[7] | dut_in[8]}};

    comb_sweep_ctrl #(
        .NUM_IN(11), .NUM_OUT(30), .SIG_W(32),
        .POLY(32'h04C1_1DB7), .SEED(32'hFFFF_FFFF), .SETTLE_CYCLES(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted),
        .dut_in(dut_in), .dut_out(dut_out),
        .signature(signature), .vec_idx(vec_idx)
`ifdef SIG_EXPECT_EN
        , .sig_expected(sig_expected), .pass(pass)
`endif
    );

    comb_sweep_ctrl #(
        .NUM_IN(2), .NUM_OUT(30), .SIG_W(32),
        .POLY(32'h04C1_1DB7), .SEED(32'h0000_0001), .SETTLE_CYCLES(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .busy(busy_s), .done(done_s), .aborted(aborted_s),
        .dut_in(dut_in_s), .dut_out(dut_out_s),
        .signature(sig_s), .vec_idx(vec_idx_s)
`ifdef SIG_EXPECT_EN
        , .sig_expected(sig_expected_s), .pass(pass_s)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Signature after the first nvec vectors of the f1 reference sweep.
    function automatic logic [31:0] modelSig(input int nvec);
        logic [31:0] s = 32'hFFFF_FFFF;
        logic [10:0] v;
        logic [31:0] fw;
        for (int i = 0; i < nvec; i++) begin
            v  = 11'(i);
            fw = (~v[7] | v[8]) ? 32'h3FFF_FFFF : 32'h0;
            s  = {s[30:0], 1'b0} ^ (s[31] ? POLY_C : 32'h0) ^ fw;
        end
        return s;
    endfunction

    // Start a sweep on the large instance; returns at the negedge after
    // the accepting edge.
    task automatic applyStimulus(input bit holdStart, input bit expectDone,
                                 input bit withAbort);
        if (expectDone) sigQ.push_back(modelSig(2048));
        @(negedge clk);
        start = 1'b1;
        abort = withAbort;
        @(posedge clk);
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic runToDone(output int k);
        k = 0;
        while (k < 5000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic checkSignature(input string tag);
        if (sigQ.size() == 0) checkOutput({tag, "_q_empty"}, 1, 0);
        else checkOutput(tag, signature, sigQ.pop_front());
    endtask

    // Vector-index scoreboard for the small instance.
    bit       seenIdx = 1'b0;
    logic [1:0] lastIdx = '0;
    always @(negedge clk) begin
        if (busy_s && (!seenIdx || vec_idx_s != lastIdx)) begin
            if (idxQ.size() == 0) checkOutput("idx_q_empty", 1, 0);
            else checkOutput("small_vec_idx", vec_idx_s, idxQ.pop_front());
            checkOutput("small_dut_in", dut_in_s, vec_idx_s);
            seenIdx <= 1'b1;
            lastIdx <= vec_idx_s;
        end
        if (!busy_s) seenIdx <= 1'b0;
    end

    initial begin
        int k;
        int w;
        bit seenDone;

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_dut_in", dut_in, 0);
        checkOutput("rst_vec_idx", vec_idx, 0);
        checkOutput("rst_signature", signature, 32'hFFFF_FFFF);
        checkOutput("rst_small_sig", sig_s, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Known signature on the small instance: 1 -> 2 -> 4 -> 8 -> 0x10.
        for (int i = 0; i < 4; i++) idxQ.push_back(2'(i));
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        w = 0;
        while (!done_s && w < 40) begin
            @(negedge clk);
            w++;
        end
        checkOutput("small_done_seen", done_s, 1);
        checkOutput("small_signature", sig_s, 32'h0000_0010);
        checkOutput("small_idx_all_seen", idxQ.size(), 0);
`ifdef SIG_EXPECT_EN
        checkOutput("small_pass", pass_s, 1);
`endif

        // Full reference sweep with a start pulse.
`ifdef SIG_EXPECT_EN
        sig_expected = modelSig(2048);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0);
        runToDone(k);
        checkOutput("latency1", k, 4096);
        checkOutput("busy_at_done", busy, 0);
        checkSignature("signature1");
`ifdef SIG_EXPECT_EN
        checkOutput("pass1", pass, 1);
`endif
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);

        // start held high: one sweep, back through IDLE, then a new sweep.
        applyStimulus(1'b1, 1'b1, 1'b0);
        runToDone(k);
        checkOutput("latency2", k, 4096);
        checkSignature("signature2");
        @(negedge clk);
        checkOutput("held_idle_busy", busy, 0);
        checkOutput("held_idle_done", done, 0);
        @(negedge clk);
        checkOutput("held_restart_busy", busy, 1);
        checkOutput("held_restart_idx", vec_idx, 0);
        start = 1'b0;

        // Abort at vector 3.
        w = 0;
        while (vec_idx != 11'd3 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("reach_idx3", (w < 50), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_flag", aborted, 1);
        checkOutput("abort_dut_in", dut_in, 0);
        checkOutput("abort_frozen_sig", signature, modelSig(3));
        seenDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) seenDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", seenDone, 0);

        // start and abort together in IDLE: start wins.
`ifdef SIG_EXPECT_EN
        sig_expected = modelSig(2048) ^ 32'h1;
`endif
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("contend_busy", busy, 1);
        checkOutput("contend_aborted", aborted, 0);
        runToDone(k);
        checkOutput("latency3", k, 4096);
        checkSignature("signature3");
`ifdef SIG_EXPECT_EN
        checkOutput("pass_flipped", pass, 0);
`endif

        // Asynchronous reset in the middle of a sweep.
        applyStimulus(1'b0, 1'b0, 1'b0);
        w = 0;
        while (vec_idx != 11'd5 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("reach_idx5", (w < 50), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_dut_in", dut_in, 0);
        checkOutput("midrst_signature", signature, 32'hFFFF_FFFF);
        checkOutput("midrst_vec_idx", vec_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
